// File: rtl/rtos_nios2_qsys_0_oci_dct_pkg.sv
// Shared widths, FSM encoding and slot helpers for the OCI data-capture-trace frame packer.
package rtos_nios2_qsys_0_oci_dct_pkg;

  localparam int DCT_BUF_W = 30;
  localparam int DCT_CNT_W = 4;
  localparam int DCT_SLOTS = 15;
  localparam int SYM_W     = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ENDING = 2'd1,
    ENDED  = 2'd2
  } dct_state_t;

  // sym_len carries slots-1; one extra bit so acc_cnt + slots cannot wrap.
  function automatic logic [DCT_CNT_W:0] sym_slots(input logic [1:0] len);
    return {3'b000, len} + 5'd1;
  endfunction

endpackage

// File: rtl/rtos_nios2_qsys_0_oci_dct_slot_insert.sv
// Masks a trace symbol to its declared slot count and ORs it into the accumulator at a slot offset.
module rtos_nios2_qsys_0_oci_dct_slot_insert
  import rtos_nios2_qsys_0_oci_dct_pkg::*;
(
  input  logic [DCT_BUF_W-1:0] acc_i,
  input  logic [DCT_CNT_W-1:0] slot_i,
  input  logic [1:0]           len_i,
  input  logic [SYM_W-1:0]     data_i,
  output logic [DCT_BUF_W-1:0] sym_o,
  output logic [DCT_BUF_W-1:0] merged_o
);

  logic [SYM_W-1:0] masked;

  // Slot gi is live only when it lies within the symbol's declared length.
  for (genvar gi = 0; gi < SYM_W / 2; gi++) begin : g_slot
    assign masked[2*gi +: 2] = (len_i >= 2'(gi)) ? data_i[2*gi +: 2] : 2'b00;
  end

  assign sym_o    = {{(DCT_BUF_W - SYM_W){1'b0}}, masked};
  assign merged_o = acc_i | (sym_o << {slot_i, 1'b0});

endmodule

// File: rtl/rtos_nios2_qsys_0_oci_dct_packer.sv
// Packs 1..4-slot trace symbols LSB-first into 30-bit DCT frames, hands them off over
// valid/ready, and runs the end-of-test handshake that flushes any partial frame.
module rtos_nios2_qsys_0_oci_dct_packer
  import rtos_nios2_qsys_0_oci_dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sym_valid,
  output logic                 sym_ready,
  input  logic [1:0]           sym_len,
  input  logic [SYM_W-1:0]     sym_data,
  input  logic                 end_req,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic [DCT_BUF_W-1:0] dct_buffer,
  output logic [DCT_CNT_W-1:0] dct_count,
  output logic                 test_ending,
  output logic                 test_has_ended,
  output logic [15:0]          frames_sent
);

  dct_state_t           state_q, state_d;
  logic [DCT_BUF_W-1:0] acc_q, acc_d;
  logic [DCT_CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [DCT_BUF_W-1:0] buf_q, buf_d;
  logic [DCT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 fv_q, fv_d;
  logic [15:0]          sent_q, sent_d;

  logic [DCT_CNT_W:0]   slots;
  logic [DCT_CNT_W:0]   fill_sum;
  logic                 fits;
  logic                 acc_empty;
  logic                 close;
  logic                 frame_taken;
  logic                 load_out;
  logic                 ready_int;
  logic                 accept;
  logic [DCT_BUF_W-1:0] sym_ext;
  logic [DCT_BUF_W-1:0] acc_merged;

  rtos_nios2_qsys_0_oci_dct_slot_insert u_slot_insert (
    .acc_i    (acc_q),
    .slot_i   (acc_cnt_q),
    .len_i    (sym_len),
    .data_i   (sym_data),
    .sym_o    (sym_ext),
    .merged_o (acc_merged)
  );

  assign slots       = sym_slots(sym_len);
  assign fill_sum    = {1'b0, acc_cnt_q} + slots;
  assign fits        = fill_sum <= 5'(DCT_SLOTS);
  assign acc_empty   = (acc_cnt_q == '0);
  // A frame closes when full, when the offered symbol would overflow it, or when flushing.
  assign close       = (acc_cnt_q == 4'(DCT_SLOTS))
                    || (sym_valid && !fits && !acc_empty)
                    || (state_q == ENDING && !acc_empty);
  assign frame_taken = fv_q && frame_ready;
  assign load_out    = close && (!fv_q || frame_ready);
  assign ready_int   = !reset && (state_q == RUN) && (fits || load_out);
  assign accept      = sym_valid && ready_int;

  always_comb begin
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    fv_d      = fv_q;
    sent_d    = sent_q;
    state_d   = state_q;

    if (load_out) begin
      buf_d     = acc_q;
      cnt_d     = acc_cnt_q;
      fv_d      = 1'b1;
      acc_d     = accept ? sym_ext : '0;
      acc_cnt_d = accept ? slots[DCT_CNT_W-1:0] : '0;
    end else begin
      if (frame_taken) fv_d = 1'b0;
      if (accept) begin
        acc_d     = acc_merged;
        acc_cnt_d = fill_sum[DCT_CNT_W-1:0];
      end
    end

    if (frame_taken) sent_d = sent_q + 16'd1;

    // ENDED is entered as soon as no frame will remain after this cycle's handshake.
    case (state_q)
      RUN:     if (end_req) state_d = ENDING;
      ENDING:  if (acc_empty && (!fv_q || frame_ready)) state_d = ENDED;
      ENDED:   state_d = ENDED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      acc_q     <= '0;
      acc_cnt_q <= '0;
      buf_q     <= '0;
      cnt_q     <= '0;
      fv_q      <= 1'b0;
      sent_q    <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      fv_q      <= fv_d;
      sent_q    <= sent_d;
    end
  end

  assign sym_ready      = ready_int;
  assign frame_valid    = fv_q;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign test_ending    = (state_q != RUN);
  assign test_has_ended = (state_q == ENDED);
  assign frames_sent    = sent_q;

endmodule

// File: tb/tb_rtos_nios2_qsys_0_oci_dct_packer.sv
// Directed bench for the DCT frame packer: fill, overflow, backpressure, end flush, reset, empty end.
module tb_rtos_nios2_qsys_0_oci_dct_packer;

  logic        clk;
  logic        reset;
  logic        sym_valid;
  logic        sym_ready;
  logic [1:0]  sym_len;
  logic [7:0]  sym_data;
  logic        end_req;
  logic        frame_valid;
  logic        frame_ready;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_ending;
  logic        test_has_ended;
  logic [15:0] frames_sent;

  int checks = 0;
  int passed = 0;

  rtos_nios2_qsys_0_oci_dct_packer dut (
    .clk            (clk),
    .reset          (reset),
    .sym_valid      (sym_valid),
    .sym_ready      (sym_ready),
    .sym_len        (sym_len),
    .sym_data       (sym_data),
    .end_req        (end_req),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .frames_sent    (frames_sent)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    reset = 1'b1; sym_valid = 1'b0; sym_len = 2'd0; sym_data = 8'h00;
    end_req = 1'b0; frame_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (frame_valid !== 1'b0) $display("FAIL rst_fv got %0b want 0", frame_valid); else passed++;
    checks++; if (dct_buffer !== 30'h0) $display("FAIL rst_buf got %h want 0", dct_buffer); else passed++;
    checks++; if (dct_count !== 4'd0) $display("FAIL rst_cnt got %0d want 0", dct_count); else passed++;
    checks++; if (sym_ready !== 1'b0) $display("FAIL rst_ready got %0b want 0", sym_ready); else passed++;
    checks++; if (test_ending !== 1'b0) $display("FAIL rst_ending got %0b want 0", test_ending); else passed++;
    checks++; if (test_has_ended !== 1'b0) $display("FAIL rst_ended got %0b want 0", test_has_ended); else passed++;
    checks++; if (frames_sent !== 16'd0) $display("FAIL rst_sent got %0d want 0", frames_sent); else passed++;
    reset = 1'b0;
    #1;
    checks++; if (sym_ready !== 1'b1) $display("FAIL rst_ready_after got %0b want 1", sym_ready); else passed++;
    $display("test_reset done");
  endtask

  task automatic test_fill();
    frame_ready = 1'b1; sym_len = 2'd2; sym_data = 8'h3F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); sym_valid = 1'b1; #1;
      checks++; if (sym_ready !== 1'b1) $display("FAIL fill_ready%0d got %0b want 1", i, sym_ready); else passed++;
    end
    @(negedge clk); sym_valid = 1'b0;
    checks++; if (frame_valid !== 1'b0) $display("FAIL fill_fv_early got %0b want 0", frame_valid); else passed++;
    @(negedge clk);
    checks++; if (frame_valid !== 1'b1) $display("FAIL fill_fv got %0b want 1", frame_valid); else passed++;
    checks++; if (dct_buffer !== 30'h3FFF_FFFF) $display("FAIL fill_buf got %h want 3fffffff", dct_buffer); else passed++;
    checks++; if (dct_count !== 4'd15) $display("FAIL fill_cnt got %0d want 15", dct_count); else passed++;
    @(negedge clk);
    checks++; if (frame_valid !== 1'b0) $display("FAIL fill_fv_clr got %0b want 0", frame_valid); else passed++;
    checks++; if (frames_sent !== 16'd1) $display("FAIL fill_sent got %0d want 1", frames_sent); else passed++;
    $display("test_fill done");
  endtask

  task automatic test_overflow();
    sym_len = 2'd1; sym_data = 8'h09;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); sym_valid = 1'b1;
    end
    @(negedge clk); sym_data = 8'h06; #1;
    checks++; if (sym_ready !== 1'b1) $display("FAIL ovf_ready got %0b want 1", sym_ready); else passed++;
    @(negedge clk); sym_valid = 1'b0;
    checks++; if (frame_valid !== 1'b1) $display("FAIL ovf_fv got %0b want 1", frame_valid); else passed++;
    checks++; if (dct_buffer !== 30'h0999_9999) $display("FAIL ovf_buf got %h want 09999999", dct_buffer); else passed++;
    checks++; if (dct_count !== 4'd14) $display("FAIL ovf_cnt got %0d want 14", dct_count); else passed++;
    @(negedge clk);
    checks++; if (frames_sent !== 16'd2) $display("FAIL ovf_sent got %0d want 2", frames_sent); else passed++;
    // Top up the restarted accumulator with 13 zero slots; upper symbol bits must be masked.
    sym_len = 2'd0; sym_data = 8'hFC;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk); sym_valid = 1'b1;
    end
    @(negedge clk); sym_valid = 1'b0;
    @(negedge clk);
    checks++; if (frame_valid !== 1'b1) $display("FAIL ovf2_fv got %0b want 1", frame_valid); else passed++;
    checks++; if (dct_buffer !== 30'h0000_0006) $display("FAIL ovf2_buf got %h want 00000006", dct_buffer); else passed++;
    checks++; if (dct_count !== 4'd15) $display("FAIL ovf2_cnt got %0d want 15", dct_count); else passed++;
    @(negedge clk);
    checks++; if (frames_sent !== 16'd3) $display("FAIL ovf2_sent got %0d want 3", frames_sent); else passed++;
    $display("test_overflow done");
  endtask

  task automatic test_backpressure();
    int acc_n;
    bit stable;
    acc_n = 0; stable = 1'b1;
    frame_ready = 1'b0; sym_len = 2'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); sym_valid = 1'b1; sym_data = 8'(acc_n % 4); #1;
      if (frame_valid && (dct_buffer !== 30'h24E4_E4E4 || dct_count !== 4'd15)) stable = 1'b0;
      if (sym_ready) acc_n++;
    end
    checks++; if (sym_ready !== 1'b0) $display("FAIL bp_ready got %0b want 0", sym_ready); else passed++;
    checks++; if (acc_n != 30) $display("FAIL bp_accepted got %0d want 30", acc_n); else passed++;
    checks++; if (stable !== 1'b1) $display("FAIL bp_stable got %0b want 1", stable); else passed++;
    checks++; if (dct_buffer !== 30'h24E4_E4E4) $display("FAIL bp_buf1 got %h want 24e4e4e4", dct_buffer); else passed++;
    @(negedge clk); sym_valid = 1'b0; frame_ready = 1'b1;
    @(negedge clk);
    checks++; if (frame_valid !== 1'b1) $display("FAIL bp_fv2 got %0b want 1", frame_valid); else passed++;
    checks++; if (dct_buffer !== 30'h1393_9393) $display("FAIL bp_buf2 got %h want 13939393", dct_buffer); else passed++;
    checks++; if (dct_count !== 4'd15) $display("FAIL bp_cnt2 got %0d want 15", dct_count); else passed++;
    checks++; if (frames_sent !== 16'd4) $display("FAIL bp_sent1 got %0d want 4", frames_sent); else passed++;
    @(negedge clk);
    checks++; if (frame_valid !== 1'b0) $display("FAIL bp_fv_clr got %0b want 0", frame_valid); else passed++;
    checks++; if (frames_sent !== 16'd5) $display("FAIL bp_sent2 got %0d want 5", frames_sent); else passed++;
    $display("test_backpressure done");
  endtask

  task automatic test_end_partial();
    sym_len = 2'd0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); sym_valid = 1'b1; sym_data = 8'(i);
    end
    @(negedge clk); sym_valid = 1'b0; end_req = 1'b1; #1;
    checks++; if (test_ending !== 1'b0) $display("FAIL end_ending_early got %0b want 0", test_ending); else passed++;
    @(negedge clk); end_req = 1'b0; sym_valid = 1'b1; #1;
    checks++; if (test_ending !== 1'b1) $display("FAIL end_ending got %0b want 1", test_ending); else passed++;
    checks++; if (sym_ready !== 1'b0) $display("FAIL end_ready got %0b want 0", sym_ready); else passed++;
    checks++; if (test_has_ended !== 1'b0) $display("FAIL end_ended_early got %0b want 0", test_has_ended); else passed++;
    @(negedge clk);
    checks++; if (frame_valid !== 1'b1) $display("FAIL end_fv got %0b want 1", frame_valid); else passed++;
    checks++; if (dct_buffer !== 30'h0000_0039) $display("FAIL end_buf got %h want 00000039", dct_buffer); else passed++;
    checks++; if (dct_count !== 4'd3) $display("FAIL end_cnt got %0d want 3", dct_count); else passed++;
    checks++; if (test_has_ended !== 1'b0) $display("FAIL end_ended_hs got %0b want 0", test_has_ended); else passed++;
    @(negedge clk);
    checks++; if (test_has_ended !== 1'b1) $display("FAIL end_ended got %0b want 1", test_has_ended); else passed++;
    checks++; if (frame_valid !== 1'b0) $display("FAIL end_fv_clr got %0b want 0", frame_valid); else passed++;
    checks++; if (frames_sent !== 16'd6) $display("FAIL end_sent got %0d want 6", frames_sent); else passed++;
    checks++; if (sym_ready !== 1'b0) $display("FAIL end_ready2 got %0b want 0", sym_ready); else passed++;
    sym_valid = 1'b0;
    $display("test_end_partial done");
  endtask

  task automatic test_reset_mid();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; frame_ready = 1'b1; sym_len = 2'd0; sym_data = 8'h01;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); sym_valid = 1'b1;
    end
    @(negedge clk); sym_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (frames_sent !== 16'd1) $display("FAIL mid_sent_pre got %0d want 1", frames_sent); else passed++;
    frame_ready = 1'b0; sym_data = 8'h02;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk); sym_valid = 1'b1;
    end
    @(negedge clk); sym_valid = 1'b0;
    checks++; if (frame_valid !== 1'b1) $display("FAIL mid_fv_pre got %0b want 1", frame_valid); else passed++;
    checks++; if (dct_buffer !== 30'h2AAA_AAAA) $display("FAIL mid_buf_pre got %h want 2aaaaaaa", dct_buffer); else passed++;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (frame_valid !== 1'b0) $display("FAIL mid_fv got %0b want 0", frame_valid); else passed++;
    checks++; if (dct_buffer !== 30'h0) $display("FAIL mid_buf got %h want 0", dct_buffer); else passed++;
    checks++; if (dct_count !== 4'd0) $display("FAIL mid_cnt got %0d want 0", dct_count); else passed++;
    checks++; if (frames_sent !== 16'd0) $display("FAIL mid_sent got %0d want 0", frames_sent); else passed++;
    checks++; if (test_ending !== 1'b0) $display("FAIL mid_ending got %0b want 0", test_ending); else passed++;
    $display("test_reset_mid done");
  endtask

  task automatic test_empty_end();
    reset = 1'b0; end_req = 1'b1; #1;
    checks++; if (sym_ready !== 1'b1) $display("FAIL empty_ready got %0b want 1", sym_ready); else passed++;
    @(negedge clk); end_req = 1'b0;
    checks++; if (test_ending !== 1'b1) $display("FAIL empty_ending got %0b want 1", test_ending); else passed++;
    checks++; if (test_has_ended !== 1'b0) $display("FAIL empty_ended_early got %0b want 0", test_has_ended); else passed++;
    @(negedge clk);
    checks++; if (test_has_ended !== 1'b1) $display("FAIL empty_ended got %0b want 1", test_has_ended); else passed++;
    checks++; if (frame_valid !== 1'b0) $display("FAIL empty_fv got %0b want 0", frame_valid); else passed++;
    end_req = 1'b1;
    @(negedge clk); end_req = 1'b0;
    @(negedge clk);
    checks++; if (frame_valid !== 1'b0) $display("FAIL empty2_fv got %0b want 0", frame_valid); else passed++;
    checks++; if (test_has_ended !== 1'b1) $display("FAIL empty2_ended got %0b want 1", test_has_ended); else passed++;
    checks++; if (frames_sent !== 16'd0) $display("FAIL empty2_sent got %0d want 0", frames_sent); else passed++;
    $display("test_empty_end done");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_backpressure();
    test_end_partial();
    test_reset_mid();
    test_empty_end();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
